// File: rtl/fifo_serializer.sv
// fifo_serializer: pops words from a first-word-fall-through FIFO and streams
// them out one bit per accepted beat, with start/end-of-frame markers and a
// running count of completed words.
module fifo_serializer #(
  parameter int bits      = 32,
  parameter bit lsb_first = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            pndng,
  input  logic [bits-1:0] Dout,
  output logic            pop,
  output logic            ser_data,
  output logic            ser_valid,
  input  logic            ser_ready,
  output logic            ser_sof,
  output logic            ser_eof,
  output logic            busy,
  output logic [15:0]     word_cnt
);

  localparam int            CW   = $clog2(bits);
  localparam logic [CW-1:0] LAST = CW'(bits - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state, state_nx;
  logic [bits-1:0] shreg, shreg_nx;
  logic [CW-1:0]   bit_cnt, bit_cnt_nx;
  logic            done;

  // Next-state: load on pop, shift on non-last beats, reload or idle on the last beat
  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    pop        = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (en && pndng) begin
          pop        = 1'b1;
          shreg_nx   = Dout;
          bit_cnt_nx = '0;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (bit_cnt == LAST) begin
            done = 1'b1;
            // Back-to-back words: reload on the eof beat so there is no bubble
            if (en && pndng) begin
              pop        = 1'b1;
              shreg_nx   = Dout;
              bit_cnt_nx = '0;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
            shreg_nx   = lsb_first ? (shreg >> 1) : (shreg << 1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // pop is combinational, so it must also drop the instant reset asserts
    if (!rst) pop = 1'b0;
  end

  // Serial-side outputs are decoded from the current state only
  always_comb begin
    busy      = (state == SHIFT);
    ser_valid = busy;
    ser_data  = busy & (lsb_first ? shreg[0] : shreg[bits-1]);
    ser_sof   = busy && (bit_cnt == '0);
    ser_eof   = busy && (bit_cnt == LAST);
  end

  // State, shift register and counters; reset discards any word in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      if (done) word_cnt <= word_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: two 8-bit instances (LSB-first and MSB-first) share one
// bench FIFO and stimulus; a queue-of-bits model is compared every cycle and
// directed tests pin literal frame contents, pop counts and word counts.
module tb_fifo_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        pndng = 1'b0;
  logic [7:0]  dout = '0;
  logic        ser_ready = 1'b1;
  logic [1:0]  pop, ser_data, ser_valid, ser_sof, ser_eof, busy;
  logic [15:0] word_cnt [2];

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo_q [$];
  logic        deq = 1'b0;

  // model state: expected remaining bits of the word in flight per instance
  bit          mq0 [$];
  bit          mq1 [$];
  logic [15:0] mwc = '0;

  logic [15:0] cap [2];
  int          vcnt = 0;
  int          popn = 0;

  logic        ep;
  int          sz;
  bit          hd;

  always #5 clk = ~clk;

  fifo_serializer #(.bits(8), .lsb_first(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .en(en), .pndng(pndng), .Dout(dout),
    .pop(pop[0]), .ser_data(ser_data[0]), .ser_valid(ser_valid[0]),
    .ser_ready(ser_ready), .ser_sof(ser_sof[0]), .ser_eof(ser_eof[0]),
    .busy(busy[0]), .word_cnt(word_cnt[0])
  );

  fifo_serializer #(.bits(8), .lsb_first(1'b0)) u_msb (
    .clk(clk), .rst(rst), .en(en), .pndng(pndng), .Dout(dout),
    .pop(pop[1]), .ser_data(ser_data[1]), .ser_valid(ser_valid[1]),
    .ser_ready(ser_ready), .ser_sof(ser_sof[1]), .ser_eof(ser_eof[1]),
    .busy(busy[1]), .word_cnt(word_cnt[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // bench FIFO: dequeue after the edge the model popped on, then refresh head
  always @(posedge clk) begin
    #1;
    if (deq && fifo_q.size() != 0) void'(fifo_q.pop_front());
    #1;
    pndng = (fifo_q.size() != 0);
    dout  = pndng ? fifo_q[0] : 8'h00;
  end

  // compare every cycle, then advance the model across the coming edge
  always @(negedge clk) begin
    if (!rst) begin
      mq0.delete();
      mq1.delete();
      mwc = '0;
    end
    ep = rst && en && pndng && ((mq0.size() == 0) || (ser_ready && mq0.size() == 1));
    for (int i = 0; i < 2; i++) begin
      sz = (i == 0) ? mq0.size() : mq1.size();
      hd = (sz == 0) ? 1'b0 : ((i == 0) ? mq0[0] : mq1[0]);
      chk($sformatf("pop[%0d]", i), pop[i], ep);
      chk($sformatf("valid[%0d]", i), ser_valid[i], sz != 0);
      chk($sformatf("busy[%0d]", i), busy[i], sz != 0);
      chk($sformatf("word_cnt[%0d]", i), word_cnt[i], mwc);
      if (sz != 0 || !rst) begin
        chk($sformatf("data[%0d]", i), ser_data[i], hd);
        chk($sformatf("sof[%0d]", i), ser_sof[i], sz == 8);
        chk($sformatf("eof[%0d]", i), ser_eof[i], sz == 1);
      end
      if (rst && ser_valid[i] && ser_ready) cap[i] = {cap[i][14:0], ser_data[i]};
    end
    if (rst && ser_valid[0]) vcnt++;
    if (rst && pop[0]) popn++;
    if (rst) begin
      if (mq0.size() != 0 && ser_ready) begin
        void'(mq0.pop_front());
        void'(mq1.pop_front());
        if (mq0.size() == 0) mwc = mwc + 16'd1;
      end
      if (ep) begin
        for (int b = 0; b < 8; b++) begin
          mq0.push_back(dout[b]);
          mq1.push_back(dout[7-b]);
        end
      end
    end
    deq = ep;
  end

  task automatic clr();
    cap[0] = '0;
    cap[1] = '0;
    vcnt   = 0;
    popn   = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!ser_valid[0] && n < 50);
    chk({nm, "_start_timeout"}, n < 50, 1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while ((ser_valid[0] || (pndng && en)) && n < 200);
    chk({nm, "_idle_timeout"}, n < 200, 1);
  endtask

  initial begin
    cap[0] = '0;
    cap[1] = '0;

    // reset held with data pending: nothing may pop or shift
    fifo_q.push_back(8'hFF);
    repeat (3) @(negedge clk);
    chk("rst_pop", pop[0], 0);
    chk("rst_valid", ser_valid[0], 0);
    chk("rst_word_cnt", word_cnt[0], 0);
    @(posedge clk); #1 rst = 1'b1; clr();
    @(negedge clk);
    chk("rel_pop", pop[0], 1);
    wait_idle("rel");
    chk("rel_bits", cap[0][7:0], 8'hFF);
    chk("rel_word_cnt", word_cnt[0], 1);

    // single word A5
    do_reset(); clr();
    fifo_q.push_back(8'hA5);
    wait_idle("single");
    chk("single_lsb_bits", cap[0][7:0], 8'hA5);
    chk("single_msb_bits", cap[1][7:0], 8'hA5);
    chk("single_pops", popn, 1);
    chk("single_valid_after", ser_valid[0], 0);
    chk("single_word_cnt", word_cnt[0], 1);

    // backpressure: ready alternates starting low on the first valid cycle
    do_reset(); clr();
    ser_ready = 1'b0;
    fifo_q.push_back(8'h3C);
    wait_valid("bp");
    repeat (15) begin @(posedge clk); #1 ser_ready = ~ser_ready; end
    wait_idle("bp");
    ser_ready = 1'b1;
    chk("bp_lsb_bits", cap[0][7:0], 8'h3C);
    chk("bp_msb_bits", cap[1][7:0], 8'h3C);
    chk("bp_valid_cycles", vcnt, 16);
    chk("bp_pops", popn, 1);
    chk("bp_word_cnt", word_cnt[0], 1);

    // back-to-back 01 then 80
    do_reset(); clr();
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h80);
    wait_idle("b2b");
    chk("b2b_lsb_bits", cap[0], 16'h8001);
    chk("b2b_msb_bits", cap[1], 16'h0180);
    chk("b2b_valid_cycles", vcnt, 16);
    chk("b2b_pops", popn, 2);
    chk("b2b_word_cnt", word_cnt[1], 2);

    // en dropped at beat 3 with another word waiting
    do_reset(); clr();
    fifo_q.push_back(8'hC0);
    fifo_q.push_back(8'h55);
    wait_valid("en");
    repeat (3) @(posedge clk);
    #1 en = 1'b0;
    wait_idle("en");
    repeat (2) @(negedge clk);
    chk("en_msb_bits", cap[1][7:0], 8'hC0);
    chk("en_lsb_bits", cap[0][7:0], 8'h03);
    chk("en_pops", popn, 1);
    chk("en_idle_valid", ser_valid[1], 0);
    chk("en_idle_pndng", pndng, 1);
    chk("en_word_cnt", word_cnt[1], 1);
    @(posedge clk); #1 en = 1'b1;
    @(negedge clk);
    chk("en_repop", pop[1], 1);
    wait_idle("en2");
    chk("en2_word_cnt", word_cnt[1], 2);

    // asynchronous reset at beat 4, word_cnt nonzero beforehand
    clr();
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'h0F);
    wait_valid("ar");
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("ar_valid", ser_valid[0], 0);
    chk("ar_busy", busy[1], 0);
    chk("ar_word_cnt0", word_cnt[0], 0);
    chk("ar_word_cnt1", word_cnt[1], 0);
    clr();
    @(posedge clk); #1 rst = 1'b1;
    wait_idle("ar");
    chk("ar_lsb_bits", cap[0][7:0], 8'hF0);
    chk("ar_msb_bits", cap[1][7:0], 8'h0F);
    chk("ar_pops", popn, 1);
    chk("ar_word_cnt", word_cnt[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
